// File: rtl/matrix_scan_scheduler_if.sv
// rtl/matrix_scan_scheduler_if.sv - back-buffer write and swap handshake bundle
//
// Purpose: groups the producer-facing write and swap handshake of the
// matrix scan scheduler.
// Signals:
//   wr_valid  producer -> scheduler  write request to the back buffer
//   wr_ready  scheduler -> producer  back buffer accepts a write
//   wr_col    producer -> scheduler  column index 0..3
//   wr_data   producer -> scheduler  row bitmap, bit r = row r lit
//   swap_req  producer -> scheduler  request a back/front swap
//   swap_ack  scheduler -> producer  one-cycle pulse when the swap happens
// Modports: master (producer side), slave (scheduler side).

interface matrix_scan_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_col;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;

  modport master (
    output wr_valid,
    output wr_col,
    output wr_data,
    output swap_req,
    input  wr_ready,
    input  swap_ack
  );

  modport slave (
    input  wr_valid,
    input  wr_col,
    input  wr_data,
    input  swap_req,
    output wr_ready,
    output swap_ack
  );
endinterface

// File: rtl/matrix_scan_scheduler.sv
// rtl/matrix_scan_scheduler.sv - double-buffered 8x4 LED matrix column scanner
//
// Purpose: time-multiplexes four columns of an 8-row LED matrix out of a
// double-buffered frame store. Each column gets BLANK_CYCLES all-off cycles
// followed by max(dwell,1) drive cycles. Buffer swaps requested by the
// producer take effect only at a frame boundary (or immediately when idle).
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       scanning enabled; low forces the matrix dark
//   dwell        drive cycles per column (0 treated as 1)
//   wr_if        slave side of the write/swap handshake
//   frame_start  pulse on the first drive cycle of column 0
//   io_out       row drive, active-low
//   io_col       column select, active-low, at most one bit low

module matrix_scan_scheduler #(
  parameter int DWELL_W      = 13,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DWELL_W-1:0]   dwell,
  matrix_scan_scheduler_if.slave wr_if,
  output logic                 frame_start,
  output logic [7:0]           io_out,
  output logic [3:0]           io_col
);

  localparam int            BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                col_q, col_d;
  logic [DWELL_W-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]             blank_q, blank_d;
  logic                      front_sel_q, front_sel_d;
  logic                      swap_pending_q, swap_pending_d;
  logic [1:0][3:0][7:0]      bank_q, bank_d;
  logic [7:0]                io_out_q, io_out_d;
  logic [3:0]                io_col_q, io_col_d;
  logic                      frame_start_q, frame_start_d;
  logic                      swap_ack_q, swap_ack_d;

  logic                      boundary;
  logic                      swap_exec;
  logic                      wr_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      col_q          <= 2'd0;
      cnt_q          <= '0;
      blank_q        <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      bank_q         <= '0;
      io_out_q       <= 8'hFF;
      io_col_q       <= 4'hF;
      frame_start_q  <= 1'b0;
      swap_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      cnt_q          <= cnt_d;
      blank_q        <= blank_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      bank_q         <= bank_d;
      io_out_q       <= io_out_d;
      io_col_q       <= io_col_d;
      frame_start_q  <= frame_start_d;
      swap_ack_q     <= swap_ack_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    cnt_d          = cnt_q;
    blank_d        = blank_q;
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    bank_d         = bank_q;
    io_out_d       = 8'hFF;
    io_col_d       = 4'hF;
    frame_start_d  = 1'b0;
    swap_ack_d     = 1'b0;
    boundary       = 1'b0;
    swap_exec      = 1'b0;
    wr_accept      = wr_if.wr_valid & ~swap_pending_q;

    case (state_q)
      S_IDLE: begin
        col_d = 2'd0;
        if (enable) begin
          state_d = S_BLANK;
          blank_d = BLANK_LOAD;
        end
      end
      S_BLANK: begin
        if (blank_q == '0) begin
          state_d = S_DRIVE;
          // dwell is sampled only here, so a change mid-column lands on the next one.
          cnt_d   = (dwell == '0) ? '0 : dwell - 1'b1;
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          col_d    = col_q + 2'd1;
          state_d  = S_BLANK;
          blank_d  = BLANK_LOAD;
          boundary = (col_q == 2'd3);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable overrides everything; a swap still pending is picked up in IDLE.
    if (!enable) begin
      state_d  = S_IDLE;
      col_d    = 2'd0;
      boundary = 1'b0;
    end

    swap_exec = swap_pending_q & (boundary | (state_q == S_IDLE));
    if (swap_exec) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end else if (wr_if.swap_req && !swap_pending_q) begin
      swap_pending_d = 1'b1;
    end
    swap_ack_d = swap_exec;

    // A write in the same cycle as a new swap_req still targets the old back bank.
    if (wr_accept) begin
      bank_d[~front_sel_q][wr_if.wr_col] = wr_if.wr_data;
    end

    // Outputs are computed from the next state so the registered pins line up
    // with the state register. The front bank never changes on a BLANK->DRIVE
    // edge, so the current front_sel is the one being displayed.
    if (state_d == S_DRIVE) begin
      io_col_d      = ~(4'b0001 << col_d);
      io_out_d      = ~bank_q[front_sel_q][col_d];
      frame_start_d = (state_q == S_BLANK) && (col_d == 2'd0);
    end
  end

  assign wr_if.wr_ready = ~swap_pending_q;
  assign wr_if.swap_ack = swap_ack_q;
  assign frame_start    = frame_start_q;
  assign io_out         = io_out_q;
  assign io_col         = io_col_q;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// tb/tb_matrix_scan_scheduler.sv - directed self-checking bench for matrix_scan_scheduler

module tb_matrix_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [12:0] dwell;
  logic        frame_start;
  logic [7:0]  io_out;
  logic [3:0]  io_col;

  int checks   = 0;
  int failures = 0;
  int acks     = 0;

  logic [7:0] pat [4] = '{8'h01, 8'h02, 8'h04, 8'h80};

  matrix_scan_scheduler_if wif();

  matrix_scan_scheduler #(
    .DWELL_W      (13),
    .BLANK_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .dwell       (dwell),
    .wr_if       (wif),
    .frame_start (frame_start),
    .io_out      (io_out),
    .io_col      (io_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scan position for dwell=3, 4 blank cycles: 7 samples per column, 28 per frame.
  function automatic logic [3:0] exp_col3(input int s);
    int p;
    int c;
    p = (s - 1) % 28;
    c = p / 7;
    return ((p % 7) >= 4) ? ~(4'b0001 << c) : 4'hF;
  endfunction

  function automatic logic is_drive3(input int s);
    return (((s - 1) % 28) % 7) >= 4;
  endfunction

  initial begin
    logic [3:0] ec;
    logic [7:0] eo;

    rst_n        = 1'b0;
    enable       = 1'b0;
    dwell        = 13'd3;
    wif.wr_valid = 1'b0;
    wif.wr_col   = 2'd0;
    wif.wr_data  = 8'h00;
    wif.swap_req = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_io_out", io_out, 8'hFF);
    chk("rst_io_col", {4'h0, io_col}, 8'h0F);
    chk("rst_wr_ready", {7'd0, wif.wr_ready}, 8'd1);
    chk("rst_swap_ack", {7'd0, wif.swap_ack}, 8'd0);
    chk("rst_frame_start", {7'd0, frame_start}, 8'd0);
    rst_n = 1'b1;
    step();
    chk("idle_io_col", {4'h0, io_col}, 8'h0F);

    // Basic scan, empty buffers, two frames.
    enable = 1'b1;
    for (int s = 1; s <= 56; s++) begin
      step();
      chk($sformatf("scan_col[%0d]", s), {4'h0, io_col}, {4'h0, exp_col3(s)});
      chk($sformatf("scan_fs[%0d]", s), {7'd0, frame_start}, {7'd0, (((s - 1) % 28) == 4)});
      chk($sformatf("scan_out[%0d]", s), io_out, 8'hFF);
    end
    enable = 1'b0;
    step();
    chk("dis1_io_col", {4'h0, io_col}, 8'h0F);

    // Fill the back bank while idle.
    for (int c = 0; c < 4; c++) begin
      wif.wr_valid = 1'b1;
      wif.wr_col   = 2'(c);
      wif.wr_data  = pat[c];
      step();
      chk($sformatf("idle_wr_ready[%0d]", c), {7'd0, wif.wr_ready}, 8'd1);
    end
    wif.wr_valid = 1'b0;

    // Swap requested together with enable; a second request and a blocked
    // write while pending; writes to the new back bank during frame 2.
    for (int s = 1; s <= 84; s++) begin
      enable       = 1'b1;
      wif.swap_req = (s == 1) || (s == 5);
      wif.wr_valid = (s == 5) || (s >= 31 && s <= 34);
      wif.wr_col   = (s == 5) ? 2'd0 : 2'(s - 31);
      wif.wr_data  = (s == 5) ? 8'hAA : 8'hFF;
      step();
      ec = exp_col3(s);
      eo = (is_drive3(s) && s > 28) ? ~pat[((s - 1) % 28) / 7] : 8'hFF;
      if (wif.swap_ack === 1'b1) acks++;
      chk($sformatf("swap_col[%0d]", s), {4'h0, io_col}, {4'h0, ec});
      chk($sformatf("swap_out[%0d]", s), io_out, eo);
      chk($sformatf("swap_ready[%0d]", s), {7'd0, wif.wr_ready}, {7'd0, (s > 28)});
      chk($sformatf("swap_ack[%0d]", s), {7'd0, wif.swap_ack}, {7'd0, (s == 29)});
    end
    wif.swap_req = 1'b0;
    wif.wr_valid = 1'b0;
    chk("swap_ack_count", 8'(acks), 8'd1);
    enable = 1'b0;
    step();
    chk("dis2_io_col", {4'h0, io_col}, 8'h0F);
    chk("dis2_io_out", io_out, 8'hFF);

    // dwell=0 behaves as one drive cycle per column.
    dwell  = 13'd0;
    enable = 1'b1;
    for (int s = 1; s <= 25; s++) begin
      step();
      ec = (((s - 1) % 5) == 4) ? ~(4'b0001 << (((s - 1) / 5) % 4)) : 4'hF;
      chk($sformatf("d0_col[%0d]", s), {4'h0, io_col}, {4'h0, ec});
      chk($sformatf("d0_fs[%0d]", s), {7'd0, frame_start}, {7'd0, (s == 5 || s == 25)});
    end
    enable = 1'b0;
    step();

    // dwell 3 -> 5 during column 0 drive: column 0 keeps 3, column 1 gets 5.
    dwell  = 13'd3;
    enable = 1'b1;
    for (int s = 1; s <= 25; s++) begin
      if (s == 6) dwell = 13'd5;
      step();
      if (s >= 5 && s <= 7)        ec = 4'hE;
      else if (s >= 12 && s <= 16) ec = 4'hD;
      else if (s >= 21)            ec = 4'hB;
      else                         ec = 4'hF;
      chk($sformatf("dchg_col[%0d]", s), {4'h0, io_col}, {4'h0, ec});
    end
    enable = 1'b0;
    step();

    // Disable mid column 2 with a swap pending; swap executes in IDLE.
    dwell = 13'd3;
    for (int s = 1; s <= 27; s++) begin
      enable       = !(s >= 20 && s <= 22);
      wif.swap_req = (s == 2);
      step();
      if (s <= 19) begin
        ec = exp_col3(s);
        eo = is_drive3(s) ? ~pat[((s - 1) % 28) / 7] : 8'hFF;
      end else if (s == 27) begin
        ec = 4'hE;
        eo = 8'h00;
      end else begin
        ec = 4'hF;
        eo = 8'hFF;
      end
      chk($sformatf("dis_col[%0d]", s), {4'h0, io_col}, {4'h0, ec});
      chk($sformatf("dis_out[%0d]", s), io_out, eo);
      chk($sformatf("dis_ready[%0d]", s), {7'd0, wif.wr_ready}, {7'd0, !(s >= 2 && s <= 20)});
      chk($sformatf("dis_ack[%0d]", s), {7'd0, wif.swap_ack}, {7'd0, (s == 21)});
      chk($sformatf("dis_fs[%0d]", s), {7'd0, frame_start}, {7'd0, (s == 5 || s == 27)});
    end
    wif.swap_req = 1'b0;

    // Asynchronous reset in the middle of a drive cycle.
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_io_col", {4'h0, io_col}, 8'h0F);
    chk("arst_io_out", io_out, 8'hFF);
    chk("arst_wr_ready", {7'd0, wif.wr_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_io_col", {4'h0, io_col}, 8'h0F);
    chk("post_rst_ack", {7'd0, wif.swap_ack}, 8'd0);
    enable = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      step();
      chk($sformatf("post_rst_col[%0d]", s), {4'h0, io_col}, {4'h0, exp_col3(s)});
      chk($sformatf("post_rst_out[%0d]", s), io_out, 8'hFF);
      chk($sformatf("post_rst_fs[%0d]", s), {7'd0, frame_start}, {7'd0, (s == 5)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
